// File: rtl/regarb_pkg.sv
// rtl/regarb_pkg.sv - shared constants and requester ids for the writeback arbiter
package regarb_pkg;

    localparam int NREG      = 17;
    localparam int SP_IDX    = 16;
    localparam int REG_IDX_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant with favoured-requester pointer
module rr_arb2
    import regarb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_alu_i,
    input  logic req_lsu_i,
    output logic gnt_alu_o,
    output logic gnt_lsu_o
);

    req_id_e ptr_q, ptr_d;

    always_comb begin
        gnt_alu_o = !rst && req_alu_i && (!req_lsu_i || (ptr_q == REQ_ALU));
        gnt_lsu_o = !rst && req_lsu_i && (!req_alu_i || (ptr_q == REQ_LSU));
        ptr_d     = ptr_q;
        // Favour whoever lost this cycle; a lone winner also hands priority over.
        if (gnt_alu_o) begin
            ptr_d = REQ_LSU;
        end else if (gnt_lsu_o) begin
            ptr_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_LSU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// rtl/regwrite_arbiter.sv - ALU/LSU writeback arbiter with busy scoreboard; REGARB_FWD_EN adds a bypass port
module regwrite_arbiter
    import regarb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_wd,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0]    lsu_wd,
    input  logic                 claim_en,
    input  logic [REG_IDX_W-1:0] claim_rd,
    input  logic [REG_IDX_W-1:0] q_rs,
    input  logic [REG_IDX_W-1:0] q_rt,
    output logic                 busy_rs,
    output logic                 busy_rt,
    output logic                 RegW,
    output logic [REG_IDX_W-1:0] Rd,
    output logic [DATA_W-1:0]    wd,
    output logic                 bad_idx
`ifdef REGARB_FWD_EN
   ,output logic                 fwd_hit_rs,
    output logic                 fwd_hit_rt,
    output logic [DATA_W-1:0]    fwd_data
`endif
);

    logic                 xfer;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [DATA_W-1:0]    sel_wd;
    logic                 sel_in_range;
    logic                 regw_q, regw_d;
    logic                 bad_q, bad_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]    wd_q, wd_d;
    logic [NREG-1:0]      busy_q, busy_d;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_alu_i (alu_valid),
        .req_lsu_i (lsu_valid),
        .gnt_alu_o (alu_ready),
        .gnt_lsu_o (lsu_ready)
    );

    always_comb begin
        xfer         = alu_ready || lsu_ready;
        sel_rd       = lsu_ready ? lsu_rd : alu_rd;
        sel_wd       = lsu_ready ? lsu_wd : alu_wd;
        sel_in_range = int'(sel_rd) < NREG;
        // R0 writes are swallowed silently; out-of-range writes are flagged instead.
        regw_d = xfer && sel_in_range && (sel_rd != '0);
        bad_d  = xfer && !sel_in_range;
        rd_d   = xfer ? sel_rd : rd_q;
        wd_d   = xfer ? sel_wd : wd_q;

        busy_d = busy_q;
        if (regw_d) begin
            busy_d[sel_rd] = 1'b0;
        end
        // A claim landing with a clear of the same register wins: a new producer is in flight.
        if (claim_en && (claim_rd != '0) && (int'(claim_rd) < NREG)) begin
            busy_d[claim_rd] = 1'b1;
        end
    end

    always_comb begin
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        if ((q_rs != '0) && (int'(q_rs) < NREG)) begin
            busy_rs = busy_q[q_rs];
        end
        if ((q_rt != '0) && (int'(q_rt) < NREG)) begin
            busy_rt = busy_q[q_rt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regw_q <= 1'b0;
            bad_q  <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            regw_q <= regw_d;
            bad_q  <= bad_d;
            rd_q   <= rd_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

    assign RegW    = regw_q;
    assign Rd      = rd_q;
    assign wd      = wd_q;
    assign bad_idx = bad_q;

`ifdef REGARB_FWD_EN
    assign fwd_hit_rs = regw_q && (rd_q == q_rs) && (rd_q != '0);
    assign fwd_hit_rt = regw_q && (rd_q == q_rt) && (rd_q != '0);
    assign fwd_data   = regw_q ? wd_q : '0;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb/tb_regwrite_arbiter.sv - directed table-driven bench for regwrite_arbiter
module tb_regwrite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_rd, lsu_rd, claim_rd, q_rs, q_rt, Rd;
    logic [31:0] alu_wd, lsu_wd, wd;
    logic        claim_en, busy_rs, busy_rt, RegW, bad_idx;
`ifdef REGARB_FWD_EN
    logic        fwd_hit_rs, fwd_hit_rt;
    logic [31:0] fwd_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regwrite_arbiter #(.DATA_W(32), .NREG(17)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
        .claim_en(claim_en), .claim_rd(claim_rd),
        .q_rs(q_rs), .q_rt(q_rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
        .RegW(RegW), .Rd(Rd), .wd(wd), .bad_idx(bad_idx)
`ifdef REGARB_FWD_EN
       ,.fwd_hit_rs(fwd_hit_rs), .fwd_hit_rt(fwd_hit_rt), .fwd_data(fwd_data)
`endif
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] awd;
        logic        lv;  logic [4:0] lrd; logic [31:0] lwd;
        logic        ce;  logic [4:0] crd; logic [4:0]  qrs;
        logic        e_ar, e_lr, e_w;
        logic [4:0]  e_rd; logic [31:0] e_wd;
        logic        e_bad, e_busy;
    } vec_t;

    vec_t tv[20];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                                input logic ce, input logic [4:0] crd, input logic [4:0] qrs,
                                input logic e_ar, input logic e_lr, input logic e_w,
                                input logic [4:0] e_rd, input logic [31:0] e_wd,
                                input logic e_bad, input logic e_busy);
        vec_t v;
        v.av = av; v.ard = ard; v.awd = awd;
        v.lv = lv; v.lrd = lrd; v.lwd = lwd;
        v.ce = ce; v.crd = crd; v.qrs = qrs;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_w = e_w;
        v.e_rd = e_rd; v.e_wd = e_wd; v.e_bad = e_bad; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_wd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wd = 0;
        claim_en = 0; claim_rd = 0; q_rs = 0; q_rt = 0;
    endtask

    initial begin
        //        av ard awd     lv lrd lwd       ce crd qrs  ar lr w  rd  wd       bad busy
        tv[0]  = mk(0, 0, 0,      1, 3, 32'h55,  0, 0, 0,    0, 1, 0, 0, 0,       0, 0);
        tv[1]  = mk(0, 0, 0,      0, 0, 0,       0, 0, 0,    0, 0, 1, 3, 32'h55,  0, 0);
        tv[2]  = mk(0, 0, 0,      0, 0, 0,       0, 0, 0,    0, 0, 0, 0, 0,       0, 0);
        tv[3]  = mk(1, 9, 32'h99, 0, 0, 0,       0, 0, 0,    1, 0, 0, 0, 0,       0, 0);
        tv[4]  = mk(1, 1, 32'h11, 1, 2, 32'h22,  0, 0, 0,    0, 1, 1, 9, 32'h99,  0, 0);
        tv[5]  = mk(1, 1, 32'h11, 1, 2, 32'h22,  0, 0, 0,    1, 0, 1, 2, 32'h22,  0, 0);
        tv[6]  = mk(1, 1, 32'h11, 1, 2, 32'h22,  0, 0, 0,    0, 1, 1, 1, 32'h11,  0, 0);
        tv[7]  = mk(1, 1, 32'h11, 1, 2, 32'h22,  0, 0, 0,    1, 0, 1, 2, 32'h22,  0, 0);
        tv[8]  = mk(0, 0, 0,      0, 0, 0,       0, 0, 0,    0, 0, 1, 1, 32'h11,  0, 0);
        tv[9]  = mk(0, 0, 0,      0, 0, 0,       1, 7, 7,    0, 0, 0, 0, 0,       0, 0);
        tv[10] = mk(1, 7, 32'h77, 0, 0, 0,       0, 0, 7,    1, 0, 0, 0, 0,       0, 1);
        tv[11] = mk(0, 0, 0,      0, 0, 0,       0, 0, 7,    0, 0, 1, 7, 32'h77,  0, 0);
        tv[12] = mk(1, 0, 32'hAA, 0, 0, 0,       0, 0, 7,    1, 0, 0, 0, 0,       0, 0);
        tv[13] = mk(1, 20, 32'hBB,0, 0, 0,       0, 0, 0,    1, 0, 0, 0, 0,       0, 0);
        tv[14] = mk(0, 0, 0,      0, 0, 0,       1, 20, 20,  0, 0, 0, 0, 0,       1, 0);
        tv[15] = mk(0, 0, 0,      1, 5, 32'h5,   1, 5, 5,    0, 1, 0, 0, 0,       0, 0);
        tv[16] = mk(0, 0, 0,      0, 0, 0,       0, 0, 5,    0, 0, 1, 5, 32'h5,   0, 1);
        tv[17] = mk(0, 0, 0,      1, 16, 1023,   1, 16, 16,  0, 1, 0, 0, 0,       0, 0);
        tv[18] = mk(0, 0, 0,      0, 0, 0,       0, 0, 16,   0, 0, 1, 16, 1023,   0, 1);
        tv[19] = mk(0, 0, 0,      0, 0, 0,       0, 0, 5,    0, 0, 0, 0, 0,       0, 1);

        // reset with a requester already valid
        idle();
        rst = 1; lsu_valid = 1; lsu_rd = 3; q_rs = 5;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_lsu_ready", lsu_ready, 0);
        chk("rst_regw", RegW, 0);
        chk("rst_rd", Rd, 0);
        chk("rst_wd", wd, 0);
        chk("rst_bad", bad_idx, 0);
        chk("rst_busy", busy_rs, 0);
        @(posedge clk); #1;
        rst = 0; idle();

        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            alu_valid = tv[i].av; alu_rd = tv[i].ard; alu_wd = tv[i].awd;
            lsu_valid = tv[i].lv; lsu_rd = tv[i].lrd; lsu_wd = tv[i].lwd;
            claim_en = tv[i].ce; claim_rd = tv[i].crd;
            q_rs = tv[i].qrs; q_rt = tv[i].qrs;
            #3;
            chk($sformatf("r%0d_alu_ready", i), alu_ready, tv[i].e_ar);
            chk($sformatf("r%0d_lsu_ready", i), lsu_ready, tv[i].e_lr);
            chk($sformatf("r%0d_regw", i), RegW, tv[i].e_w);
            chk($sformatf("r%0d_bad_idx", i), bad_idx, tv[i].e_bad);
            chk($sformatf("r%0d_busy_rs", i), busy_rs, tv[i].e_busy);
            chk($sformatf("r%0d_busy_rt", i), busy_rt, tv[i].e_busy);
            if (tv[i].e_w) begin
                chk($sformatf("r%0d_rd", i), Rd, tv[i].e_rd);
                chk($sformatf("r%0d_wd", i), wd, tv[i].e_wd);
            end
        end

`ifdef REGARB_FWD_EN
        @(posedge clk); #1;
        idle(); lsu_valid = 1; lsu_rd = 16; lsu_wd = 1023;
        @(posedge clk); #1;
        idle(); q_rt = 16; q_rs = 3;
        #3;
        chk("fwd_hit_rt", fwd_hit_rt, 1);
        chk("fwd_hit_rs", fwd_hit_rs, 0);
        chk("fwd_data", fwd_data, 1023);
        @(posedge clk); #4;
        chk("fwd_idle_hit", fwd_hit_rt, 0);
        chk("fwd_idle_data", fwd_data, 0);
`endif

        // reset arriving while a write is pending, pointer left on ALU
        @(posedge clk); #1;
        idle(); lsu_valid = 1; lsu_rd = 4; lsu_wd = 32'h44;
        #3;
        chk("mid_lsu_ready", lsu_ready, 1);
        @(posedge clk); #1;
        rst = 1; alu_valid = 1; alu_rd = 6; q_rs = 5;
        #3;
        chk("mid_regw_before", RegW, 1);
        chk("mid_rd_before", Rd, 4);
        chk("mid_ready_in_rst", {alu_ready, lsu_ready}, 0);
        @(posedge clk); #4;
        chk("mid_regw_after", RegW, 0);
        chk("mid_rd_after", Rd, 0);
        chk("mid_wd_after", wd, 0);
        chk("mid_busy_cleared", busy_rs, 0);
        @(posedge clk); #1;
        rst = 0;
        #3;
        chk("mid_ptr_lsu", lsu_ready, 1);
        chk("mid_ptr_alu", alu_ready, 0);
        @(posedge clk); #1;
        idle();
        #3;
        chk("mid_post_regw", RegW, 1);
        chk("mid_post_rd", Rd, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
